// File: rtl/pid_channel_scheduler.sv
// ============================================================================
// Module   : pid_channel_scheduler
// Brief    : Frame-rate controller that time-shares one PID core across
//            NUM_CHN motor channels, with per-channel timeout and overrun flag.
//            Optional output clamp: define PID_SAT_CLAMP_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pid_channel_scheduler #(
    parameter int DATA_WIDTH     = 16,
    parameter int NUM_CHN        = 4,
    parameter int CHN_WIDTH      = 3,
    parameter int CLK_FREQ       = 27_000_000,
    parameter int CTRL_FREQ      = 1_000,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int RPM_MAX        = 1500
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en_i,
    input  logic                          clr_err_i,
    input  logic [NUM_CHN*DATA_WIDTH-1:0] setpoint_i,
    input  logic [NUM_CHN*DATA_WIDTH-1:0] speed_i,
    output logic                          pid_start_o,
    output logic [CHN_WIDTH-1:0]          pid_chn_o,
    output logic [DATA_WIDTH-1:0]         pid_setpoint_o,
    output logic [DATA_WIDTH-1:0]         pid_feedback_o,
    input  logic                          pid_done_i,
    input  logic [DATA_WIDTH-1:0]         pid_data_i,
    output logic                          u_valid_o,
    output logic [CHN_WIDTH-1:0]          u_chn_o,
    output logic [DATA_WIDTH-1:0]         u_data_o,
    output logic                          busy_o,
    output logic                          overrun_o,
    output logic                          timeout_err_o,
    output logic [CHN_WIDTH-1:0]          err_chn_o
);

    localparam int CTRL_PERIOD = CLK_FREQ / CTRL_FREQ;
    localparam int TICK_W      = (CTRL_PERIOD > 1) ? $clog2(CTRL_PERIOD) : 1;
    localparam int TO_W        = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

`ifdef PID_SAT_CLAMP_EN
    localparam bit c_clamp_en = 1'b1;
`else
    localparam bit c_clamp_en = 1'b0;
`endif
    localparam logic signed [DATA_WIDTH-1:0] c_pos_lim = DATA_WIDTH'(RPM_MAX);
    localparam logic signed [DATA_WIDTH-1:0] c_neg_lim = DATA_WIDTH'(-RPM_MAX);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_EMIT   = 2'd3
    } state_t;

    state_t                r_state;
    logic [TICK_W-1:0]     r_tick_cnt;
    logic [TO_W-1:0]       r_to_cnt;
    logic [CHN_WIDTH-1:0]  r_chn;
    logic [DATA_WIDTH-1:0] r_sp_snap [NUM_CHN];
    logic [DATA_WIDTH-1:0] r_fb_snap [NUM_CHN];

    logic                  w_tick;
    logic                  w_last_chn;
    logic [CHN_WIDTH-1:0]  w_next_chn;
    logic [DATA_WIDTH-1:0] w_next_sp;
    logic [DATA_WIDTH-1:0] w_next_fb;
    logic [DATA_WIDTH-1:0] w_result;

    assign w_tick     = (r_tick_cnt == TICK_W'(CTRL_PERIOD - 1));
    assign w_last_chn = (r_chn == CHN_WIDTH'(NUM_CHN - 1));
    assign w_next_chn = r_chn + 1'b1;
    assign busy_o     = (r_state != S_IDLE);

    // Snapshot of the channel that the next LAUNCH will address
    always_comb begin
        w_next_sp = '0;
        w_next_fb = '0;
        for (int i = 0; i < NUM_CHN; i++) begin
            if (w_next_chn == CHN_WIDTH'(i)) begin
                w_next_sp = r_sp_snap[i];
                w_next_fb = r_fb_snap[i];
            end
        end
    end

    always_comb begin
        w_result = pid_data_i;
        if (c_clamp_en) begin
            if ($signed(pid_data_i) > c_pos_lim) begin
                w_result = c_pos_lim;
            end else if ($signed(pid_data_i) < c_neg_lim) begin
                w_result = c_neg_lim;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_tick_cnt     <= '0;
            r_to_cnt       <= '0;
            r_chn          <= '0;
            pid_start_o    <= 1'b0;
            pid_chn_o      <= '0;
            pid_setpoint_o <= '0;
            pid_feedback_o <= '0;
            u_valid_o      <= 1'b0;
            u_chn_o        <= '0;
            u_data_o       <= '0;
            overrun_o      <= 1'b0;
            timeout_err_o  <= 1'b0;
            err_chn_o      <= '0;
            for (int i = 0; i < NUM_CHN; i++) begin
                r_sp_snap[i] <= '0;
                r_fb_snap[i] <= '0;
            end
        end else begin
            r_tick_cnt  <= w_tick ? '0 : r_tick_cnt + 1'b1;
            pid_start_o <= 1'b0;
            u_valid_o   <= 1'b0;

            // Clear first so that a same-cycle error event overrides it
            if (clr_err_i) begin
                overrun_o     <= 1'b0;
                timeout_err_o <= 1'b0;
                err_chn_o     <= '0;
            end
            if (w_tick && (r_state != S_IDLE)) begin
                overrun_o <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_tick && en_i) begin
                        for (int i = 0; i < NUM_CHN; i++) begin
                            r_sp_snap[i] <= setpoint_i[i*DATA_WIDTH +: DATA_WIDTH];
                            r_fb_snap[i] <= speed_i[i*DATA_WIDTH +: DATA_WIDTH];
                        end
                        r_chn          <= '0;
                        pid_start_o    <= 1'b1;
                        pid_chn_o      <= '0;
                        pid_setpoint_o <= setpoint_i[DATA_WIDTH-1:0];
                        pid_feedback_o <= speed_i[DATA_WIDTH-1:0];
                        r_state        <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    r_to_cnt <= '0;
                    r_state  <= S_WAIT;
                end
                S_WAIT: begin
                    if (pid_done_i) begin
                        u_valid_o <= 1'b1;
                        u_chn_o   <= r_chn;
                        u_data_o  <= w_result;
                        r_state   <= S_EMIT;
                    end else if (r_to_cnt == TO_W'(TIMEOUT_CYCLES)) begin
                        u_valid_o     <= 1'b1;
                        u_chn_o       <= r_chn;
                        u_data_o      <= '0;
                        timeout_err_o <= 1'b1;
                        err_chn_o     <= r_chn;
                        r_state       <= S_EMIT;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                S_EMIT: begin
                    if (w_last_chn) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_chn          <= w_next_chn;
                        pid_start_o    <= 1'b1;
                        pid_chn_o      <= w_next_chn;
                        pid_setpoint_o <= w_next_sp;
                        pid_feedback_o <= w_next_fb;
                        r_state        <= S_LAUNCH;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pid_channel_scheduler.sv
// ============================================================================
// Module   : tb_pid_channel_scheduler
// Brief    : Self-checking bench for pid_channel_scheduler with a PID-core
//            responder and a frame-level schedule model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pid_channel_scheduler;

    localparam int DW = 16;
    localparam int NC = 4;
    localparam int CW = 3;
    localparam int PERIOD = 100;
    localparam int TO_CYC = 255;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           en_i = 1'b0;
    logic           clr_err_i = 1'b0;
    logic [NC*DW-1:0] setpoint_i = '0;
    logic [NC*DW-1:0] speed_i = '0;
    logic           pid_start_o;
    logic [CW-1:0]  pid_chn_o;
    logic [DW-1:0]  pid_setpoint_o;
    logic [DW-1:0]  pid_feedback_o;
    logic           pid_done_i = 1'b0;
    logic [DW-1:0]  pid_data_i = '0;
    logic           u_valid_o;
    logic [CW-1:0]  u_chn_o;
    logic [DW-1:0]  u_data_o;
    logic           busy_o;
    logic           overrun_o;
    logic           timeout_err_o;
    logic [CW-1:0]  err_chn_o;

    pid_channel_scheduler #(
        .DATA_WIDTH(DW), .NUM_CHN(NC), .CHN_WIDTH(CW),
        .CLK_FREQ(1000), .CTRL_FREQ(10), .TIMEOUT_CYCLES(TO_CYC), .RPM_MAX(1500)
    ) dut (
        .clk(clk), .rst(rst), .en_i(en_i), .clr_err_i(clr_err_i),
        .setpoint_i(setpoint_i), .speed_i(speed_i),
        .pid_start_o(pid_start_o), .pid_chn_o(pid_chn_o),
        .pid_setpoint_o(pid_setpoint_o), .pid_feedback_o(pid_feedback_o),
        .pid_done_i(pid_done_i), .pid_data_i(pid_data_i),
        .u_valid_o(u_valid_o), .u_chn_o(u_chn_o), .u_data_o(u_data_o),
        .busy_o(busy_o), .overrun_o(overrun_o),
        .timeout_err_o(timeout_err_o), .err_chn_o(err_chn_o)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; logic [CW-1:0] chn; logic [DW-1:0] sp; logic [DW-1:0] fb; } launch_t;
    typedef struct { int cyc; logic [CW-1:0] chn; logic [DW-1:0] data; bit is_to; } emit_t;

    launch_t lq[$];
    emit_t   eq[$];

    int n_assert = 0;
    int n_fail   = 0;
    int cyc = 0;

    // Frame schedule model state
    int m_cnt = 0, m_last_tick = -1000, m_busy_from = 0, m_busy_until = -1;
    int m_lat = 4, m_silent = -1, m_mode = 0, m_scr = 0, m_l1 = -1;
    bit m_ovr = 0, m_to = 0;
    logic [CW-1:0] m_errchn = '0;

    // PID core responder state
    bit p_pend = 0;
    int p_launch = 0;
    logic [CW-1:0] p_chn = '0;
    logic [DW-1:0] p_val = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] resp_value(input logic [CW-1:0] c,
                                                input logic [DW-1:0] sp, input logic [DW-1:0] fb);
        if (m_mode == 0) return sp - fb + 16'd5;
        case (c)
            3'd0:    return 16'd2000;
            3'd1:    return 16'(-3000);
            3'd2:    return 16'd1500;
            default: return 16'(-1501);
        endcase
    endfunction

    function automatic logic [DW-1:0] exp_clamp(input logic [DW-1:0] v);
`ifdef PID_SAT_CLAMP_EN
        if ($signed(v) > 16'sd1500) return 16'd1500;
        if ($signed(v) < -16'sd1500) return 16'(-1500);
`endif
        return v;
    endfunction

    function automatic bit busy_at(input int k);
        return (k >= m_busy_from) && (k <= m_busy_until);
    endfunction

    // Tick in cycle t: one LAUNCH/WAIT.../EMIT slot per channel, back to back
    task automatic start_frame(input int t);
        int l, e, dur;
        logic [DW-1:0] sp, fb, d;
        l = t + 1;
        for (int c = 0; c < NC; c++) begin
            sp  = setpoint_i[c*DW +: DW];
            fb  = speed_i[c*DW +: DW];
            dur = (c == m_silent) ? (TO_CYC + 3) : (m_lat + 2);
            e   = l + dur - 1;
            d   = (c == m_silent) ? 16'd0 : exp_clamp(resp_value(3'(c), sp, fb));
            lq.push_back('{l, 3'(c), sp, fb});
            eq.push_back('{e, 3'(c), d, (c == m_silent)});
            l = e + 1;
        end
        m_busy_from  = t + 1;
        m_busy_until = l - 1;
    endtask

    task automatic end_of_cycle();
        bit tick, bsy;
        if (rst) begin
            m_cnt = 0; lq.delete(); eq.delete();
            m_busy_from = 0; m_busy_until = -1;
            m_ovr = 0; m_to = 0; m_errchn = '0; p_pend = 0;
            return;
        end
        tick  = (m_cnt == PERIOD - 1);
        m_cnt = tick ? 0 : m_cnt + 1;
        bsy   = busy_at(cyc);
        if (tick) m_last_tick = cyc;
        if (clr_err_i) begin m_ovr = 0; m_to = 0; m_errchn = '0; end
        if (tick && bsy) m_ovr = 1;
        if (eq.size() > 0 && eq[0].cyc == cyc + 1 && eq[0].is_to) begin
            m_to = 1; m_errchn = eq[0].chn;
        end
        if (tick && !bsy && en_i) start_frame(cyc);
    endtask

    task automatic sample();
        bit exp_s, exp_v;
        chk("busy", busy_o, busy_at(cyc));
        chk("overrun", overrun_o, m_ovr);
        chk("timeout_err", timeout_err_o, m_to);
        chk("err_chn", err_chn_o, m_errchn);
        exp_s = (lq.size() > 0) && (lq[0].cyc == cyc);
        chk("pid_start", pid_start_o, exp_s);
        if (exp_s) begin
            chk("pid_chn", pid_chn_o, lq[0].chn);
            chk("pid_setpoint", pid_setpoint_o, lq[0].sp);
            chk("pid_feedback", pid_feedback_o, lq[0].fb);
            void'(lq.pop_front());
        end
        exp_v = (eq.size() > 0) && (eq[0].cyc == cyc);
        chk("u_valid", u_valid_o, exp_v);
        if (exp_v) begin
            chk("u_chn", u_chn_o, eq[0].chn);
            chk("u_data", u_data_o, eq[0].data);
            void'(eq.pop_front());
        end
        if (pid_start_o) begin
            p_pend = 1; p_launch = cyc; p_chn = pid_chn_o;
            p_val = resp_value(pid_chn_o, pid_setpoint_o, pid_feedback_o);
            if (pid_chn_o == 3'd1) m_l1 = cyc;
        end
        pid_data_i = 16'($urandom());
        pid_done_i = 1'b0;
        if (p_pend && cyc == p_launch + m_lat && int'(p_chn) != m_silent) begin
            pid_done_i = 1'b1; pid_data_i = p_val; p_pend = 0;
        end else if (!p_pend && !busy_at(cyc) && $urandom_range(0, 7) == 0) begin
            pid_done_i = 1'b1;
        end
    endtask

    task automatic step();
        end_of_cycle();
        @(posedge clk);
        #1;
        cyc++;
        sample();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            if (m_scr == 2) begin
                setpoint_i = {$urandom(), $urandom()};
                speed_i    = {$urandom(), $urandom()};
            end else if (m_scr == 1 && cyc == m_last_tick + 2) begin
                setpoint_i = {16'd7, 16'd7, 16'd7, 16'd7};
            end
            step();
        end
    endtask

    // Leaves the bench in a cycle where the tick counter is at its wrap value
    task automatic align();
        for (int i = 0; i < 2 * PERIOD && m_cnt != PERIOD - 1; i++) step();
    endtask

    task automatic reset_check();
        chk("rst pid_start", pid_start_o, 0);
        chk("rst pid_chn", pid_chn_o, 0);
        chk("rst pid_setpoint", pid_setpoint_o, 0);
        chk("rst pid_feedback", pid_feedback_o, 0);
        chk("rst u_valid", u_valid_o, 0);
        chk("rst u_chn", u_chn_o, 0);
        chk("rst u_data", u_data_o, 0);
        chk("rst busy", busy_o, 0);
        chk("rst overrun", overrun_o, 0);
        chk("rst timeout_err", timeout_err_o, 0);
        chk("rst err_chn", err_chn_o, 0);
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        run(3);
        reset_check();
        rst = 1'b0;

        // Basic frame, setpoints change two cycles after the tick
        align();
        setpoint_i = {16'(-400), 16'd300, 16'(-200), 16'd100};
        speed_i = '0;
        m_lat = 4; m_mode = 0; m_scr = 1; en_i = 1'b1;
        run(1);
        en_i = 1'b0;
        run(40);
        m_scr = 0;

        // Disabled: no frames across several ticks
        run(300);

        // Randomized frames with inputs changing every cycle
        for (int f = 0; f < 4; f++) begin
            align();
            m_lat = int'($urandom_range(1, 10));
            m_scr = 2; en_i = 1'b1;
            run(1);
            en_i = 1'($urandom_range(0, 1));
            run(60);
            en_i = 1'b0;
            m_scr = 0;
        end

        // Channel 2 never answers
        align();
        setpoint_i = {16'd40, 16'd30, 16'd20, 16'd10};
        speed_i = {16'd4, 16'd3, 16'd2, 16'd1};
        m_lat = 4; m_silent = 2; en_i = 1'b1;
        run(1);
        en_i = 1'b0;
        run(300);
        clr_err_i = 1'b1;
        run(1);
        clr_err_i = 1'b0;
        run(5);
        m_silent = -1;

        // Slow PID core: overrun, then a clean following frame
        align();
        m_lat = 40; en_i = 1'b1;
        run(201);
        en_i = 1'b0;
        run(200);
        clr_err_i = 1'b1;
        run(1);
        clr_err_i = 1'b0;

        // Saturating results
        align();
        m_mode = 1; m_lat = 3; en_i = 1'b1;
        run(1);
        en_i = 1'b0;
        run(30);
        m_mode = 0;

        // Reset while waiting on channel 1
        align();
        m_lat = 20; m_l1 = -1; en_i = 1'b1;
        run(1);
        en_i = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (m_l1 >= 0 && cyc >= m_l1 + 5) break;
        end
        chk("busy before reset", busy_o, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        reset_check();
        run(150);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pid_channel_scheduler.md
Name: pid_channel_scheduler

Overview:
- Frame-rate controller that time-shares one PID core across NUM_CHN motor channels.
- On each control tick it snapshots all setpoints and measured speeds, then launches the PID core once per channel, in channel order.
- It collects each result and emits it as a u_valid_o/u_chn_o/u_data_o strobe, which feeds the PWM output processor directly.
- It guards against a hung PID core with a per-channel timeout and flags frame overruns.

Parameters:
DATA_WIDTH, 16, signed width of setpoint, speed and PID output
NUM_CHN, 4, number of motor channels
CHN_WIDTH, 3, channel index width
CLK_FREQ, 27_000_000, clock frequency in Hz
CTRL_FREQ, 1_000, control-loop rate in Hz; CTRL_PERIOD = CLK_FREQ/CTRL_FREQ cycles (default 27000)
TIMEOUT_CYCLES, 255, maximum number of WAIT cycles per channel before the timeout fires
RPM_MAX, 1500, clamp limit (used only with the optional feature)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
en_i  in  1  enable; new frames start only while en_i=1
clr_err_i  in  1  clears the sticky error flags
setpoint_i  in  NUM_CHN*DATA_WIDTH  per-channel setpoints, channel 0 in the LSBs
speed_i  in  NUM_CHN*DATA_WIDTH  per-channel measured speeds, channel 0 in the LSBs
pid_start_o  out  1  one-cycle launch pulse to the PID core
pid_chn_o  out  CHN_WIDTH  channel index of the current launch
pid_setpoint_o  out  DATA_WIDTH  snapshot setpoint of pid_chn_o
pid_feedback_o  out  DATA_WIDTH  snapshot speed of pid_chn_o
pid_done_i  in  1  PID result valid, single-cycle
pid_data_i  in  DATA_WIDTH  signed PID result
u_valid_o  out  1  one-cycle result strobe to the PWM processor
u_chn_o  out  CHN_WIDTH  channel index of the result
u_data_o  out  DATA_WIDTH  signed result
busy_o  out  1  high whenever state is not IDLE
overrun_o  out  1  sticky: a tick arrived while busy
timeout_err_o  out  1  sticky: the PID core did not answer in time
err_chn_o  out  CHN_WIDTH  channel of the most recent timeout

Behaviour:
- Reset (rst=1 at a clk edge): every output goes to 0; state=IDLE; tick counter=0; snapshot registers=0. Reset mid-frame aborts the frame with no further strobes.
- Tick counter:
  - Counts 0..CTRL_PERIOD-1 and wraps; it free-runs regardless of en_i.
  - The internal tick is high for the single cycle in which the counter equals CTRL_PERIOD-1.
- States: IDLE, LAUNCH, WAIT, EMIT.
- IDLE:
  - On tick with en_i=1: register all setpoint_i/speed_i into snapshots, set chn=0, go to LAUNCH.
  - On tick with en_i=0: stay in IDLE.
- LAUNCH (exactly 1 cycle):
  - pid_start_o=1, with pid_chn_o/pid_setpoint_o/pid_feedback_o driven from the snapshot of chn.
  - Clear the timeout counter, go to WAIT.
  - pid_chn_o, pid_setpoint_o and pid_feedback_o hold their values until the next LAUNCH.
- WAIT:
  - If pid_done_i=1: capture pid_data_i, go to EMIT.
  - Else if timeout counter == TIMEOUT_CYCLES: result=0, timeout_err_o<=1, err_chn_o<=chn, go to EMIT.
  - Else: increment the timeout counter.
  - done and timeout in the same cycle: done wins, no error.
- EMIT (exactly 1 cycle):
  - u_valid_o=1, u_chn_o=chn, u_data_o=result.
  - u_chn_o and u_data_o hold until the next EMIT.
  - If chn==NUM_CHN-1 go to IDLE; else chn+1 and go to LAUNCH.
- Latency:
  - Tick in cycle T: pid_start_o is high in T+1.
  - pid_done_i in cycle D: u_valid_o is high in D+1.
  - Minimum per channel is 3 cycles (LAUNCH, WAIT, EMIT).
- pid_done_i outside WAIT is ignored.
- Overrun: a tick while state≠IDLE sets overrun_o; the tick is dropped and the current frame continues unchanged.
- en_i deasserted mid-frame: the current frame completes; no new frame starts.
- clr_err_i=1 clears overrun_o, timeout_err_o and err_chn_o. If a new error event occurs in the same cycle, the set wins.
- Signedness: all data is two's complement; the result is passed through unmodified unless the optional feature is enabled.

Optional Feature:
PID_SAT_CLAMP_EN
- Defined: the captured pid_data_i is clamped to [-RPM_MAX, +RPM_MAX] using a signed compare before EMIT, so u_data_o never exceeds ±1500.
- Undefined: pid_data_i is passed through unchanged.
- Timeout forcing of the result to 0 applies in both builds.

Test Plan:
- All scenarios use CLK_FREQ=1000, CTRL_FREQ=10 (CTRL_PERIOD=100).
- Basic frame: setpoints {100,-200,300,-400}, speeds 0, PID model answers setpoint+5 after 4 cycles -> four u_valid_o strobes, u_chn_o 0..3, u_data_o {105,-195,305,-395}; pid_start_o one cycle after the tick; each u_valid_o exactly one cycle after pid_done_i.
- Timeout: PID model never answers for channel 2 -> channel 2 strobe fires 257 cycles after its launch with u_data_o=0; timeout_err_o=1, err_chn_o=2; channel 3 still processed; clr_err_i clears the flags.
- Overrun: PID latency 40 cycles -> a frame needs more than 100 cycles, so the next tick arrives while busy -> overrun_o=1, no restart of the current frame, the following frame starts cleanly.
- Enable/reset: en_i=0 -> no pid_start_o for 300 cycles; rst asserted during WAIT of channel 1 -> all outputs 0 the next cycle and no further u_valid_o.
- Snapshot coherence: setpoint_i changes 2 cycles after the tick -> the frame uses the pre-change values for all channels.
- Clamp (PID_SAT_CLAMP_EN defined): PID returns 2000 and -3000 -> u_data_o 1500 and -1500; without the macro -> 2000 and -3000.
